// File: rtl/hdmi_infoframe_pkg.sv
// Shared definitions for HDMI InfoFrame receivers.
//
// Contents:
//   - AVI InfoFrame header constants (type, version, length, frame size)
//   - avi_error cause codes
//   - receiver state encoding
//   - decoded AVI field bundle and its reset value
//   - helper mapping a payload byte number (PBn) to its stream index
package hdmi_infoframe_pkg;

  localparam logic [7:0]  AVI_TYPE        = 8'h82;
  localparam logic [7:0]  AVI_VERSION     = 8'd2;
  localparam logic [4:0]  AVI_LENGTH      = 5'd13;
  localparam int unsigned INFOFRAME_BYTES = 31;
  localparam int unsigned HEADER_BYTES    = 3;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_HEADER   = 2'b01;
  localparam logic [1:0] ERR_CHECKSUM = 2'b10;
  localparam logic [1:0] ERR_TRUNC    = 2'b11;

  // Receiver states
  typedef logic [1:0] rx_state_t;
  localparam rx_state_t ST_IDLE    = 2'd0;
  localparam rx_state_t ST_COLLECT = 2'd1;
  localparam rx_state_t ST_SKIP    = 2'd2;

  typedef struct packed {
    logic [1:0] video_format;
    logic [1:0] scan_info;
    logic [1:0] colorimetry;
    logic [1:0] picture_aspect_ratio;
    logic [3:0] active_format_aspect_ratio;
    logic       it_content;
    logic [1:0] rgb_quantization_range;
    logic [6:0] video_id_code;
    logic [1:0] ycc_quantization_range;
    logic [1:0] content_type;
    logic [3:0] pixel_repetition;
  } avi_fields_t;

  // AFAR 4'b1000 means "same as picture aspect ratio", the neutral default.
  localparam avi_fields_t AVI_FIELDS_RESET = '{
    video_format:               2'b00,
    scan_info:                  2'b00,
    colorimetry:                2'b00,
    picture_aspect_ratio:       2'b00,
    active_format_aspect_ratio: 4'b1000,
    it_content:                 1'b0,
    rgb_quantization_range:     2'b00,
    video_id_code:              7'd0,
    ycc_quantization_range:     2'b00,
    content_type:               2'b00,
    pixel_repetition:           4'd0
  };

  // Stream index of payload byte PBn (HB0..HB2 occupy indices 0..2).
  function automatic logic [4:0] pb_idx(input int unsigned pb);
    return 5'(pb + HEADER_BYTES);
  endfunction

endpackage

// File: rtl/infoframe_rx_collector.sv
// Byte-serial InfoFrame framing helper: byte index, running checksum and
// inter-byte gap timer. Packet-type agnostic so it can serve any InfoFrame
// receiver.
//
// Ports:
//   clk_pixel, reset  clock, synchronous active-high reset
//   active            owning FSM is inside a packet (COLLECT or SKIP)
//   in_valid          in_byte valid this cycle
//   in_first          in_byte is HB0 of a new packet (starts a packet in any state)
//   in_byte           packet byte
//   byte_idx          index of the byte presented this cycle (0..30)
//   sum_zero          running sum of indices 0..LAST_SUM_IDX is 0 mod 256
//   pkt_done          last byte (index 30) accepted this cycle
//   pkt_abort         GAP_TIMEOUT-th consecutive idle cycle inside a packet
module infoframe_rx_collector
  import hdmi_infoframe_pkg::*;
#(
  parameter int unsigned LAST_SUM_IDX = 16,
  parameter int unsigned GAP_TIMEOUT  = 64
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic       active,
  input  logic       in_valid,
  input  logic       in_first,
  input  logic [7:0] in_byte,
  output logic [4:0] byte_idx,
  output logic       sum_zero,
  output logic       pkt_done,
  output logic       pkt_abort
);

  // Counter holds 0..GAP_TIMEOUT-1; reaching the limit aborts instead of wrapping.
  localparam int unsigned GAP_W = (GAP_TIMEOUT > 2) ? $clog2(GAP_TIMEOUT) : 1;

  logic [4:0]       idx_q;
  logic [7:0]       sum_q;
  logic [GAP_W-1:0] gap_q;
  logic             start;
  logic             accept;

  assign start     = in_valid & in_first;
  assign accept    = active & in_valid & ~in_first;
  assign pkt_done  = accept & (idx_q == 5'(INFOFRAME_BYTES - 1));
  assign pkt_abort = active & ~in_valid & (gap_q == GAP_W'(GAP_TIMEOUT - 1));
  assign byte_idx  = idx_q;
  assign sum_zero  = (sum_q == 8'd0);

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      idx_q <= 5'd0;
      sum_q <= 8'd0;
      gap_q <= '0;
    end else if (start) begin
      idx_q <= 5'd1;
      sum_q <= in_byte;
      gap_q <= '0;
    end else if (accept) begin
      idx_q <= pkt_done ? 5'd0 : idx_q + 5'd1;
      // Bytes past the declared length are padding and stay out of the checksum.
      if (idx_q <= 5'(LAST_SUM_IDX)) begin
        sum_q <= sum_q + in_byte;
      end
      gap_q <= '0;
    end else if (active) begin
      gap_q <= pkt_abort ? '0 : gap_q + 1'b1;
    end else begin
      gap_q <= '0;
    end
  end

endmodule

// File: rtl/avi_info_frame_receiver.sv
// HDMI AVI InfoFrame (type 0x82) sink-side parser.
//
// Consumes the byte-serial data-island stream HB0..HB2, PB0..PB27, validates
// header and checksum, and publishes the decoded AVI fields one cycle after
// PB27. Other packet types are swallowed silently.
//
// Build option: define AVI_RX_BAR_INFO_EN to capture the bar_* fields from
// PB6..PB13; otherwise bar_* are constant zero and no capture logic exists.
//
// Ports:
//   clk_pixel, reset          clock, synchronous active-high reset
//   in_valid/in_first/in_byte byte stream; in_first marks HB0
//   avi_update                1-cycle pulse: packet accepted, fields updated
//   avi_error                 1-cycle pulse: AVI packet rejected
//   error_code                cause of last avi_error (01 hdr, 10 sum, 11 trunc)
//   video_format .. pixel_repetition   decoded PB1..PB5 fields
//   bar_top/bottom/left/right PB7:PB6, PB9:PB8, PB11:PB10, PB13:PB12
module avi_info_frame_receiver
  import hdmi_infoframe_pkg::*;
#(
  parameter logic [7:0]  EXPECTED_VERSION = AVI_VERSION,
  parameter logic [4:0]  EXPECTED_LENGTH  = AVI_LENGTH,
  parameter int unsigned GAP_TIMEOUT      = 64
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_first,
  input  logic [7:0]  in_byte,
  output logic        avi_update,
  output logic        avi_error,
  output logic [1:0]  error_code,
  output logic [1:0]  video_format,
  output logic [1:0]  scan_info,
  output logic [1:0]  colorimetry,
  output logic [1:0]  picture_aspect_ratio,
  output logic [3:0]  active_format_aspect_ratio,
  output logic        it_content,
  output logic [1:0]  rgb_quantization_range,
  output logic [6:0]  video_id_code,
  output logic [1:0]  ycc_quantization_range,
  output logic [1:0]  content_type,
  output logic [3:0]  pixel_repetition,
  output logic [15:0] bar_top,
  output logic [15:0] bar_bottom,
  output logic [15:0] bar_left,
  output logic [15:0] bar_right
);

  localparam int unsigned LAST_SUM_IDX = HEADER_BYTES + 32'(EXPECTED_LENGTH);

  localparam logic [4:0] IDX_HB1 = 5'd1;
  localparam logic [4:0] IDX_HB2 = 5'd2;
  localparam logic [4:0] IDX_PB1 = pb_idx(1);
  localparam logic [4:0] IDX_PB2 = pb_idx(2);
  localparam logic [4:0] IDX_PB3 = pb_idx(3);
  localparam logic [4:0] IDX_PB4 = pb_idx(4);
  localparam logic [4:0] IDX_PB5 = pb_idx(5);

  rx_state_t   state_q, state_d;
  logic        hdr_err_q, hdr_err_d;
  logic        update_q, error_q;
  logic [1:0]  code_q;
  logic        fire_update, fire_error;
  logic [1:0]  err_d;
  avi_fields_t shadow_q, live_q;

  logic [4:0]  byte_idx;
  logic        sum_zero, pkt_done, pkt_abort;
  logic        start, collect_byte;

  assign start        = in_valid & in_first;
  assign collect_byte = (state_q == ST_COLLECT) & in_valid & ~in_first;

  infoframe_rx_collector #(
    .LAST_SUM_IDX (LAST_SUM_IDX),
    .GAP_TIMEOUT  (GAP_TIMEOUT)
  ) u_collector (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .active    (state_q != ST_IDLE),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_byte   (in_byte),
    .byte_idx  (byte_idx),
    .sum_zero  (sum_zero),
    .pkt_done  (pkt_done),
    .pkt_abort (pkt_abort)
  );

  // Packet-level control. A new HB0 always wins: it abandons whatever packet
  // is in flight and is parsed as the start of the next one in the same cycle.
  always_comb begin
    state_d     = state_q;
    hdr_err_d   = hdr_err_q;
    fire_update = 1'b0;
    fire_error  = 1'b0;
    err_d       = ERR_NONE;
    if (start) begin
      state_d   = (in_byte == AVI_TYPE) ? ST_COLLECT : ST_SKIP;
      hdr_err_d = 1'b0;
      if (state_q == ST_COLLECT) begin
        fire_error = 1'b1;
        err_d      = ERR_TRUNC;
      end
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (pkt_abort) begin
            state_d    = ST_IDLE;
            fire_error = 1'b1;
            err_d      = ERR_TRUNC;
          end else if (in_valid) begin
            // Header mismatches are remembered and reported at packet end.
            if (byte_idx == IDX_HB1 && in_byte != EXPECTED_VERSION) begin
              hdr_err_d = 1'b1;
            end
            if (byte_idx == IDX_HB2 && in_byte[4:0] != EXPECTED_LENGTH) begin
              hdr_err_d = 1'b1;
            end
            if (pkt_done) begin
              state_d = ST_IDLE;
              if (hdr_err_q) begin
                fire_error = 1'b1;
                err_d      = ERR_HEADER;
              end else if (!sum_zero) begin
                fire_error = 1'b1;
                err_d      = ERR_CHECKSUM;
              end else begin
                fire_update = 1'b1;
              end
            end
          end
        end
        ST_SKIP: begin
          if (pkt_abort || pkt_done) begin
            state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hdr_err_q <= 1'b0;
      update_q  <= 1'b0;
      error_q   <= 1'b0;
      code_q    <= ERR_NONE;
      live_q    <= AVI_FIELDS_RESET;
    end else begin
      state_q   <= state_d;
      hdr_err_q <= hdr_err_d;
      update_q  <= fire_update;
      error_q   <= fire_error;
      if (fire_error) begin
        code_q <= err_d;
      end
      if (fire_update) begin
        live_q <= shadow_q;
      end
    end
  end

  // Shadow copy filled during COLLECT so the live fields never change mid-packet.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      shadow_q <= AVI_FIELDS_RESET;
    end else if (collect_byte) begin
      case (byte_idx)
        IDX_PB1: begin
          shadow_q.video_format <= in_byte[6:5];
          shadow_q.scan_info    <= in_byte[1:0];
        end
        IDX_PB2: begin
          shadow_q.colorimetry                <= in_byte[7:6];
          shadow_q.picture_aspect_ratio       <= in_byte[5:4];
          shadow_q.active_format_aspect_ratio <= in_byte[3:0];
        end
        IDX_PB3: begin
          shadow_q.it_content             <= in_byte[7];
          shadow_q.rgb_quantization_range <= in_byte[3:2];
        end
        IDX_PB4: begin
          shadow_q.video_id_code <= in_byte[6:0];
        end
        IDX_PB5: begin
          shadow_q.ycc_quantization_range <= in_byte[7:6];
          shadow_q.content_type           <= in_byte[5:4];
          shadow_q.pixel_repetition       <= in_byte[3:0];
        end
        default: ;
      endcase
    end
  end

`ifdef AVI_RX_BAR_INFO_EN
  localparam logic [4:0] IDX_PB6  = pb_idx(6);
  localparam logic [4:0] IDX_PB13 = pb_idx(13);

  logic             bar_valid_q;
  logic [7:0][7:0]  bar_bytes_q;
  logic [3:0][15:0] bar_q;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      bar_valid_q <= 1'b0;
      bar_bytes_q <= '0;
    end else if (collect_byte) begin
      if (byte_idx == IDX_PB1) begin
        bar_valid_q <= (in_byte[3:2] != 2'b00);
      end
      if (byte_idx >= IDX_PB6 && byte_idx <= IDX_PB13) begin
        bar_bytes_q[3'(byte_idx - IDX_PB6)] <= in_byte;
      end
    end
  end

  // Byte k of bar_bytes_q is PB(6+k), so each 16-bit lane is little-endian.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      bar_q <= '0;
    end else if (fire_update) begin
      bar_q <= bar_valid_q ? bar_bytes_q : '0;
    end
  end

  assign bar_top    = bar_q[0];
  assign bar_bottom = bar_q[1];
  assign bar_left   = bar_q[2];
  assign bar_right  = bar_q[3];
`else
  assign bar_top    = 16'd0;
  assign bar_bottom = 16'd0;
  assign bar_left   = 16'd0;
  assign bar_right  = 16'd0;
`endif

  assign avi_update                 = update_q;
  assign avi_error                  = error_q;
  assign error_code                 = code_q;
  assign video_format               = live_q.video_format;
  assign scan_info                  = live_q.scan_info;
  assign colorimetry                = live_q.colorimetry;
  assign picture_aspect_ratio       = live_q.picture_aspect_ratio;
  assign active_format_aspect_ratio = live_q.active_format_aspect_ratio;
  assign it_content                 = live_q.it_content;
  assign rgb_quantization_range     = live_q.rgb_quantization_range;
  assign video_id_code              = live_q.video_id_code;
  assign ycc_quantization_range     = live_q.ycc_quantization_range;
  assign content_type               = live_q.content_type;
  assign pixel_repetition           = live_q.pixel_repetition;

endmodule

// File: tb/tb_avi_info_frame_receiver.sv
// Scoreboard bench for avi_info_frame_receiver: the stimulus thread queues the
// expected pulse (cycle, kind, code, fields, bars); a monitor pops and compares
// whenever avi_update or avi_error is seen.
module tb_avi_info_frame_receiver;

  logic        clk_pixel = 1'b0;
  logic        reset     = 1'b1;
  logic        in_valid  = 1'b0;
  logic        in_first  = 1'b0;
  logic [7:0]  in_byte   = 8'd0;
  logic        avi_update, avi_error, it_content;
  logic [1:0]  error_code, video_format, scan_info, colorimetry, picture_aspect_ratio;
  logic [1:0]  rgb_quantization_range, ycc_quantization_range, content_type;
  logic [3:0]  active_format_aspect_ratio, pixel_repetition;
  logic [6:0]  video_id_code;
  logic [15:0] bar_top, bar_bottom, bar_left, bar_right;

  avi_info_frame_receiver dut (
    .clk_pixel                  (clk_pixel),
    .reset                      (reset),
    .in_valid                   (in_valid),
    .in_first                   (in_first),
    .in_byte                    (in_byte),
    .avi_update                 (avi_update),
    .avi_error                  (avi_error),
    .error_code                 (error_code),
    .video_format               (video_format),
    .scan_info                  (scan_info),
    .colorimetry                (colorimetry),
    .picture_aspect_ratio       (picture_aspect_ratio),
    .active_format_aspect_ratio (active_format_aspect_ratio),
    .it_content                 (it_content),
    .rgb_quantization_range     (rgb_quantization_range),
    .video_id_code              (video_id_code),
    .ycc_quantization_range     (ycc_quantization_range),
    .content_type               (content_type),
    .pixel_repetition           (pixel_repetition),
    .bar_top                    (bar_top),
    .bar_bottom                 (bar_bottom),
    .bar_left                   (bar_left),
    .bar_right                  (bar_right)
  );

  always #5 clk_pixel = ~clk_pixel;

  int cyc = 0;
  always @(posedge clk_pixel) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic        is_update;
    int          at;
    logic [1:0]  code;
    logic [29:0] fields;
    logic [63:0] bars;
    logic [6:0]  vic;
    logic [3:0]  afar;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  pkt [0:30];
  int          last_cyc;
  logic [1:0]  cur_code;
  logic [29:0] cur_fields;
  logic [63:0] cur_bars;
  logic [6:0]  cur_vic;
  logic [3:0]  cur_afar;

  localparam logic [29:0] RESET_FIELDS = {8'h00, 4'b1000, 18'h0};

  logic [29:0] dut_fields;
  logic [63:0] dut_bars;
  assign dut_fields = {video_format, scan_info, colorimetry, picture_aspect_ratio,
                       active_format_aspect_ratio, it_content, rgb_quantization_range,
                       video_id_code, ycc_quantization_range, content_type, pixel_repetition};
  assign dut_bars   = {bar_right, bar_left, bar_bottom, bar_top};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Field packing mirrors dut_fields ordering; bit positions from the AVI layout.
  function automatic logic [29:0] decode_pkt();
    return {pkt[4][6:5], pkt[4][1:0], pkt[5][7:6], pkt[5][5:4], pkt[5][3:0],
            pkt[6][7], pkt[6][3:2], pkt[7][6:0], pkt[8][7:6], pkt[8][5:4], pkt[8][3:0]};
  endfunction

  always @(negedge clk_pixel) begin
    if (!reset && (avi_update || avi_error)) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: got update=%0b error=%0b expected none (cycle %0d)",
                 avi_update, avi_error, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_kind", {avi_update, avi_error}, e.is_update ? 2'b10 : 2'b01);
        check("pulse_cycle", cyc, e.at);
        check("error_code", error_code, e.code);
        check("fields", dut_fields, e.fields);
        check("video_id_code", video_id_code, e.vic);
        check("afar", active_format_aspect_ratio, e.afar);
        check("bars", dut_bars, e.bars);
      end
    end
  end

  task automatic drive(input logic v, input logic f, input logic [7:0] b);
    @(posedge clk_pixel);
    #1;
    in_valid = v;
    in_first = f;
    in_byte  = b;
    last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) drive(1'b1, i == 0, pkt[i]);
  endtask

  task automatic build(input logic [7:0] hb0, input logic [7:0] pb0, input logic [7:0] pb1,
                       input logic [7:0] pb2, input logic [7:0] pb3, input logic [7:0] pb4,
                       input logic [7:0] pb5);
    for (int i = 0; i < 31; i++) pkt[i] = 8'h00;
    pkt[0] = hb0;
    pkt[1] = 8'h02;
    pkt[2] = 8'h0D;
    pkt[3] = pb0;
    pkt[4] = pb1;
    pkt[5] = pb2;
    pkt[6] = pb3;
    pkt[7] = pb4;
    pkt[8] = pb5;
  endtask

  task automatic expect_update(input logic [63:0] bars, input logic [6:0] vic,
                               input logic [3:0] afar);
    exp_t e;
    e.is_update = 1'b1;
    e.at        = last_cyc + 1;
    e.code      = cur_code;
    e.fields    = decode_pkt();
    e.bars      = bars;
    e.vic       = vic;
    e.afar      = afar;
    sb.push_back(e);
    cur_fields = e.fields;
    cur_bars   = bars;
    cur_vic    = vic;
    cur_afar   = afar;
  endtask

  task automatic expect_error(input logic [1:0] code);
    exp_t e;
    e.is_update = 1'b0;
    e.at        = last_cyc + 1;
    e.code      = code;
    e.fields    = cur_fields;
    e.bars      = cur_bars;
    e.vic       = cur_vic;
    e.afar      = cur_afar;
    sb.push_back(e);
    cur_code = code;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] exp_bars6;
    cur_code   = 2'b00;
    cur_fields = RESET_FIELDS;
    cur_bars   = 64'd0;
    cur_vic    = 7'd0;
    cur_afar   = 4'b1000;

    repeat (3) @(posedge clk_pixel);
    @(negedge clk_pixel);
    check("reset_update", avi_update, 1'b0);
    check("reset_error", avi_error, 1'b0);
    check("reset_code", error_code, 2'b00);
    check("reset_fields", dut_fields, RESET_FIELDS);
    check("reset_afar", active_format_aspect_ratio, 4'b1000);
    check("reset_bars", dut_bars, 64'd0);
    @(posedge clk_pixel);
    #1 reset = 1'b0;
    idle(2);

    // 1: default packet, contiguous
    build(8'h82, 8'h63, 8'h00, 8'h08, 8'h00, 8'h04, 8'h00);
    send_range(0, 30);
    expect_update(64'd0, 7'd4, 4'h8);
    idle(3);

    // 2: bad checksum keeps previous fields
    pkt[3] = 8'h64;
    send_range(0, 30);
    expect_error(2'b10);
    idle(3);

    // Header error wins over checksum error (sum is also wrong here)
    pkt[3] = 8'h63;
    pkt[1] = 8'h03;
    send_range(0, 30);
    expect_error(2'b01);
    idle(3);

    // Non-zero bytes past PB13 are outside the checksum; 63-cycle gap tolerated
    build(8'h82, 8'hCE, 8'h40, 8'h1A, 8'h88, 8'h5F, 8'h60);
    for (int i = 17; i < 31; i++) pkt[i] = 8'hFF;
    send_range(0, 8);
    idle(63);
    send_range(9, 30);
    expect_update(64'd0, 7'd95, 4'hA);
    idle(3);

    // 3: audio InfoFrame swallowed, then back-to-back valid AVI packet
    build(8'h84, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 1; i < 31; i++) pkt[i] = 8'(i * 7);
    send_range(0, 30);
    build(8'h82, 8'h63, 8'h00, 8'h08, 8'h00, 8'h04, 8'h00);
    send_range(0, 30);
    expect_update(64'd0, 7'd4, 4'h8);
    idle(3);

    // 4: stall after PB10 for 64 cycles, trailing bytes ignored
    send_range(0, 13);
    idle(64);
    expect_error(2'b11);
    send_range(14, 30);
    idle(3);

    // 5: in_first at PB20 restarts with a new packet carrying VIC 16
    send_range(0, 22);
    build(8'h82, 8'h57, 8'h00, 8'h08, 8'h00, 8'h10, 8'h00);
    send_range(0, 0);
    expect_error(2'b11);
    send_range(1, 30);
    expect_update(64'd0, 7'd16, 4'h8);
    idle(3);

    // 6: bar info present (PB1[3:2]=11)
`ifdef AVI_RX_BAR_INFO_EN
    exp_bars6 = 64'h0000_0000_0000_1234;
`else
    exp_bars6 = 64'd0;
`endif
    build(8'h82, 8'h11, 8'h0C, 8'h08, 8'h00, 8'h04, 8'h00);
    pkt[9]  = 8'h34;
    pkt[10] = 8'h12;
    send_range(0, 30);
    expect_update(exp_bars6, 7'd4, 4'h8);
    idle(3);

    // Bar bytes present but PB1[3:2]=00: bars cleared
    build(8'h82, 8'h1D, 8'h00, 8'h08, 8'h00, 8'h04, 8'h00);
    pkt[9]  = 8'h34;
    pkt[10] = 8'h12;
    send_range(0, 30);
    expect_update(64'd0, 7'd4, 4'h8);
    idle(3);

    // Reset mid-packet: no pulse, fields back to defaults, remainder ignored
    build(8'h82, 8'h63, 8'h00, 8'h08, 8'h00, 8'h04, 8'h00);
    send_range(0, 15);
    @(posedge clk_pixel);
    #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge clk_pixel);
    #1 reset = 1'b0;
    cur_code   = 2'b00;
    cur_fields = RESET_FIELDS;
    cur_bars   = 64'd0;
    @(negedge clk_pixel);
    check("post_reset_fields", dut_fields, cur_fields);
    check("post_reset_code", error_code, cur_code);
    send_range(16, 30);
    idle(10);

    check("pending_expectations", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/avi_info_frame_receiver.md
Name: avi_info_frame_receiver

Overview:
- Sink-side parser for HDMI Auxiliary Video InfoFrames, i.e. type 0x82, version 2, length 13.
- Consumes a byte-serial data-island packet stream in order HB0..HB2, then PB0..PB27 (31 bytes).
- Validates header and checksum, then latches the decoded AVI fields for the downstream video pipeline (colour-space / scaler control).
- Non-AVI packets on the same stream (audio InfoFrame, ACR, ...) are consumed and ignored silently.

Parameters:
- EXPECTED_VERSION, 8'd2, HB1 value required for acceptance.
- EXPECTED_LENGTH, 5'd13, required HB2[4:0]; it is also the last PB index included in the checksum.
- GAP_TIMEOUT, 64, max idle cycles (in_valid low) allowed inside a packet before it is abandoned; must be ≥2.

Ports:
- clk_pixel  in  1  sole clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  in_byte valid this cycle
- in_first  in  1  qualifies the HB0 byte (start of packet); meaningful only with in_valid
- in_byte  in  8  packet byte
- avi_update  out  1  one-cycle pulse: new AVI packet accepted, fields updated
- avi_error  out  1  one-cycle pulse: AVI packet rejected
- error_code  out  2  cause of last avi_error: 01 header, 10 checksum, 11 truncated; held until next error
- video_format  out  2  PB1[6:5]
- scan_info  out  2  PB1[1:0]
- colorimetry  out  2  PB2[7:6]
- picture_aspect_ratio  out  2  PB2[5:4]
- active_format_aspect_ratio  out  4  PB2[3:0]
- it_content  out  1  PB3[7]
- rgb_quantization_range  out  2  PB3[3:2]
- video_id_code  out  7  PB4[6:0]
- ycc_quantization_range  out  2  PB5[7:6]
- content_type  out  2  PB5[5:4]
- pixel_repetition  out  4  PB5[3:0]
- bar_top, bar_bottom, bar_left, bar_right  out  16 each  PB7:PB6, PB9:PB8, PB11:PB10, PB13:PB12 (see Optional Feature)

Behaviour:
- States:
  - IDLE: waiting for in_valid && in_first.
  - COLLECT: 5-bit byte index 0..30, 8-bit running sum mod 256, idle-gap counter.
  - SKIP: non-AVI packet, bytes consumed until index 30.
- IDLE:
  - in_valid without in_first is ignored.
  - in_valid && in_first: index←1, sum←in_byte, enter COLLECT if in_byte==8'h82, else SKIP.
- COLLECT:
  - Index 1 (HB1) and index 2 (HB2) are checked against EXPECTED_VERSION and EXPECTED_LENGTH.
  - A mismatch is flagged but collection continues to index 30; the error is reported at packet end.
  - Sum covers HB0..HB2 and PB0..PB(EXPECTED_LENGTH), i.e. indices 0..16. PB14..PB27 are consumed but not summed.
  - PB bytes are captured into a shadow register; live outputs do not change mid-packet.
- Packet end (byte index 30 accepted):
  - Return to IDLE.
  - Next cycle: if header ok and sum==0, shadow→outputs and avi_update=1.
  - Else avi_error=1 with error_code 01 (header takes priority) or 10; outputs keep prior values.
- Latency: pulses and field updates appear exactly 1 cycle after the cycle in which PB27 is presented.
- Gaps: in_valid may drop at any point. The gap counter resets on each accepted byte.
  - Reaching GAP_TIMEOUT consecutive idle cycles in COLLECT aborts the packet: avi_error=1, code 11, next cycle, then IDLE.
  - In SKIP the same timeout returns to IDLE with no pulse.
- in_first mid-packet (COLLECT or SKIP):
  - Current packet is abandoned. COLLECT → avi_error code 11 next cycle; SKIP → silent.
  - The byte is processed as HB0 of a new packet in the same cycle.
  - If timeout expiry and in_first coincide, only one error pulse is produced.
- avi_update and avi_error are never high together.
- Reset values:
  - State IDLE, pulses 0, error_code 00.
  - All fields 0 except active_format_aspect_ratio=4'b1000.
  - Bars 0.
  - Reset mid-packet discards it with no pulse.

Optional Feature:
- AVI_RX_BAR_INFO_EN
  - Defined: bar_* outputs are captured from PB6..PB13 on accepted packets, little-endian 16-bit; they update only when PB1[3:2]!=00, otherwise they are set to 0.
  - Undefined: bar_* tied to 16'd0; no capture registers are built. Checksum is unaffected either way.

Decomposition:
- Package hdmi_infoframe_pkg:
  - AVI_TYPE=8'h82, AVI_VERSION=8'd2, AVI_LENGTH=5'd13, INFOFRAME_BYTES=31.
  - Error code constants ERR_NONE/ERR_HEADER/ERR_CHECKSUM/ERR_TRUNC.
  - State enum.
- Sub-module infoframe_rx_collector: byte index, running checksum, and gap timer. It emits byte_idx, sum_zero, pkt_done and pkt_abort, and is reusable for the audio InfoFrame receiver.

Test Plan:
1. Default AVI packet, contiguous: HB 82 02 0D, PB0=63 PB2=08 PB4=04, rest 00 → avi_update 1 cycle after PB27; video_id_code=4, active_format_aspect_ratio=8, error_code=00.
2. Same packet with PB0=64 → avi_error, error_code=10; fields retain previous values.
3. HB0=84 audio InfoFrame of 31 bytes, then the valid packet from (1) → no pulse for the first packet, avi_update for the second.
4. Valid packet stalled after PB10 for 64 cycles → avi_error code 11 at gap cycle 64. Later bytes without in_first are ignored.
5. in_first asserted at PB20 of a valid packet carrying a new valid packet with PB4=10 → error 11 pulse, then avi_update with video_id_code=16.
6. With AVI_RX_BAR_INFO_EN: PB1=0C, PB6/7=34 12, PB0 adjusted → bar_top=16'h1234. Without the macro → bar_top=0.
